// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the fetch unit and its next-PC helper.
//   - fetch_state_t : fetch/issue FSM states
//   - instr_t       : 16-bit instruction word
//   - field positions of op, funct, imm6 and the jump target
//   - OP_HALT       : opcode that stops fetching when the halt feature is built in
//   - sext_imm      : sign-extends imm6 to 32 bits
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef logic [15:0] instr_t;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int FUNCT_HI = 2;
  localparam int FUNCT_LO = 0;
  localparam int IMM_W    = 6;
  localparam int JADDR_W  = 12;

  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc: combinational next-PC select for the fetch unit.
//   pc    in  PC_W : address of the instruction being consumed
//   instr in  16   : that instruction word
//   pcsrc in  1    : branch taken -> pc + 1 + sext(imm6)
//   jump  in  1    : jump -> zero-extended instr[11:0]; overrides pcsrc
//   npc   out PC_W : next fetch address (all arithmetic wraps modulo 2^PC_W)
import mips_pkg::*;

module next_pc #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  instr_t          instr,
  input  logic            pcsrc,
  input  logic            jump,
  output logic [PC_W-1:0] npc
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] jmp_pc;
  logic [3:0]      unused_op;

  // The opcode plays no part in the address choice.
  assign unused_op = instr[OP_HI:OP_LO];

  assign seq_pc = pc + PC_W'(32'd1);
  assign br_pc  = seq_pc + PC_W'(sext_imm(instr[IMM_W-1:0]));
  // Casting the zero-extended target to PC_W truncates or pads as needed.
  assign jmp_pc = PC_W'({{(32-JADDR_W){1'b0}}, instr[JADDR_W-1:0]});

  // Priority select: jump, then branch, then sequential.
  always_comb begin
    npc = seq_pc;
    if (jump) begin
      npc = jmp_pc;
    end else if (pcsrc) begin
      npc = br_pc;
    end else begin
      npc = seq_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and issue stage of the multicycle core.
// Holds the PC, fetches 16-bit words over a req/ack handshake and presents each
// one with a valid flag; the controller's pcsrc/jump decision, sampled when the
// issued instruction is consumed (stall=0), picks the next PC.
//   clk, reset_n          : clock, asynchronous active-low reset
//   imem_req/imem_addr    : fetch request and word address (registered)
//   imem_ack/imem_rdata   : memory accept and instruction word
//   stall                 : downstream not ready to consume the issued instruction
//   pcsrc, jump           : next-PC decision for the issued instruction
//   valid/instr/op/funct/pc : issued instruction (registered)
//   halted                : halt opcode consumed
// Optional feature macro FETCH_HALT_EN: an op=4'hF instruction, once consumed,
// parks the unit in HALT until reset; without it op=4'hF issues normally and
// halted is tied 0.
import mips_pkg::*;

module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            stall,
  input  logic            pcsrc,
  input  logic            jump,
  output logic            valid,
  output logic [15:0]     instr,
  output logic [3:0]      op,
  output logic [2:0]      funct,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic [PC_W-1:0] npc;
  logic            halt_op;
  logic            consume;

  next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc    (pc),
    .instr (instr),
    .pcsrc (pcsrc),
    .jump  (jump),
    .npc   (npc)
  );

  assign op      = instr[OP_HI:OP_LO];
  assign funct   = instr[FUNCT_HI:FUNCT_LO];
  assign consume = (state == ISSUE) && !stall;

`ifdef FETCH_HALT_EN
  assign halt_op = (instr[OP_HI:OP_LO] == OP_HALT);
`else
  assign halt_op = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = FETCH;
      FETCH: begin
        if (imem_ack) begin
          next_state = ISSUE;
        end else begin
          next_state = FETCH;
        end
      end
      ISSUE: begin
        if (stall) begin
          next_state = ISSUE;
        end else if (halt_op) begin
          next_state = HALT;
        end else begin
          next_state = FETCH;
        end
      end
`ifdef FETCH_HALT_EN
      HALT:    next_state = HALT;
`else
      HALT:    next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs and PC. imem_addr only moves when FETCH is entered,
  // and the PC stays frozen once a halt opcode is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      valid     <= 1'b0;
      instr     <= 16'h0000;
      pc        <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            valid    <= 1'b1;
            imem_req <= 1'b0;
          end
        end
        ISSUE: begin
          if (consume) begin
            valid <= 1'b0;
            if (!halt_op) begin
              pc        <= npc;
              imem_addr <= npc;
              imem_req  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_HALT_EN
  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted <= 1'b0;
    end else if (consume && halt_op) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (PC_W=8, RESET_PC=0).
// A table of fetch/issue records drives the memory handshake, stall and
// next-PC inputs; issued words go through a scoreboard queue. Hand-written
// sequences cover reset release, reset mid-fetch and the halt opcode.
module tb_fetch_unit;

  localparam int PC_W = 8;

  logic            clk;
  logic            reset_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic            stall;
  logic            pcsrc;
  logic            jump;
  logic            valid;
  logic [15:0]     instr;
  logic [3:0]      op;
  logic [2:0]      funct;
  logic [PC_W-1:0] pc;
  logic            halted;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .jump       (jump),
    .valid      (valid),
    .instr      (instr),
    .op         (op),
    .funct      (funct),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  exp_pc;
    logic        br;
    logic        jmp;
    int          ack_dly;
    int          stall_n;
    logic [7:0]  exp_next;
  } vec_t;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  pc;
  } sb_t;

  vec_t vecs [10];
  sb_t  sb_q [$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, ":req"}, 32'(imem_req), 32'd1);
  endtask

  // Ack the pending fetch with word and check the issued outputs via the scoreboard.
  task automatic ack_and_issue(input string tag, input logic [15:0] word, input logic [7:0] exp_pc,
                               output sb_t e);
    imem_ack   = 1'b1;
    imem_rdata = word;
    sb_q.push_back('{word, exp_pc});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    check({tag, ":valid"}, 32'(valid), 32'd1);
    check({tag, ":req_low"}, 32'(imem_req), 32'd0);
    e = '{16'h0000, 8'h00};
    if (valid === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, ":instr"}, 32'(instr), 32'(e.word));
      check({tag, ":pc"}, 32'(pc), 32'(e.pc));
      check({tag, ":op"}, 32'(op), 32'(e.word[15:12]));
      check({tag, ":funct"}, 32'(funct), 32'(e.word[2:0]));
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    sb_t   e;
    t = $sformatf("v%0d", idx);
    wait_req(t);
    check({t, ":addr"}, 32'(imem_addr), 32'(v.exp_pc));
    for (int d = 0; d < v.ack_dly; d++) begin
      imem_ack = 1'b0;
      tick();
      check({t, ":wait_req"}, 32'(imem_req), 32'd1);
      check({t, ":wait_addr"}, 32'(imem_addr), 32'(v.exp_pc));
      check({t, ":wait_valid"}, 32'(valid), 32'd0);
    end
    ack_and_issue(t, v.word, v.exp_pc, e);
    // Stalled cycles: pcsrc/jump wiggle but must have no effect.
    for (int s = 0; s < v.stall_n; s++) begin
      stall = 1'b1;
      pcsrc = 1'($urandom);
      jump  = 1'($urandom);
      tick();
      check({t, ":stall_valid"}, 32'(valid), 32'd1);
      check({t, ":stall_instr"}, 32'(instr), 32'(v.word));
      check({t, ":stall_pc"}, 32'(pc), 32'(v.exp_pc));
      check({t, ":stall_req"}, 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    pcsrc = v.br;
    jump  = v.jmp;
    tick();
    pcsrc = 1'b0;
    jump  = 1'b0;
    check({t, ":valid_drop"}, 32'(valid), 32'd0);
    check({t, ":next_req"}, 32'(imem_req), 32'd1);
    check({t, ":next_addr"}, 32'(imem_addr), 32'(v.exp_next));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":req"}, 32'(imem_req), 32'd0);
    check({tag, ":addr"}, 32'(imem_addr), 32'd0);
    check({tag, ":valid"}, 32'(valid), 32'd0);
    check({tag, ":instr"}, 32'(instr), 32'd0);
    check({tag, ":op"}, 32'(op), 32'd0);
    check({tag, ":funct"}, 32'(funct), 32'd0);
    check({tag, ":pc"}, 32'(pc), 32'd0);
    check({tag, ":halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    sb_t  e;
    //           word      pc     br    jmp   dly stl next
    vecs[0] = '{16'h1234, 8'h00, 1'b0, 1'b0, 0, 0, 8'h01}; // sequential
    vecs[1] = '{16'h2005, 8'h01, 1'b0, 1'b1, 3, 0, 8'h05}; // late ack, jump
    vecs[2] = '{16'h003E, 8'h05, 1'b1, 1'b0, 0, 0, 8'h04}; // branch -2
    vecs[3] = '{16'hA111, 8'h04, 1'b0, 1'b0, 1, 4, 8'h05}; // stall, noisy pcsrc
    vecs[4] = '{16'h40A0, 8'h05, 1'b0, 1'b1, 0, 0, 8'hA0}; // jump to A0
    vecs[5] = '{16'h50BE, 8'hA0, 1'b1, 1'b1, 0, 1, 8'hBE}; // jump beats branch
    vecs[6] = '{16'h60FF, 8'hBE, 1'b0, 1'b1, 0, 0, 8'hFF}; // jump to FF
    vecs[7] = '{16'h7000, 8'hFF, 1'b0, 1'b0, 2, 0, 8'h00}; // wrap FF->00
    vecs[8] = '{16'h8001, 8'h00, 1'b1, 1'b0, 0, 0, 8'h02}; // branch +1
    vecs[9] = '{16'h9E7F, 8'h02, 1'b1, 1'b0, 0, 2, 8'h02}; // branch -1

    reset_n    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    stall      = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");

    reset_n = 1'b1;
    check("idle_req", 32'(imem_req), 32'd0);
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset mid-fetch with an ack pending: immediate reset values, ack dropped.
    check("pre_rst_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late_ack_valid", 32'(valid), 32'd0);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", 32'(imem_addr), 32'd0);
    run_vec('{16'h1234, 8'h00, 1'b0, 1'b0, 0, 0, 8'h01}, 10);

`ifdef FETCH_HALT_EN
    wait_req("halt");
    check("halt:addr", 32'(imem_addr), 32'd1);
    ack_and_issue("halt", 16'hF000, 8'h01, e);
    stall = 1'b0;
    tick();
    check("halt:halted", 32'(halted), 32'd1);
    check("halt:valid", 32'(valid), 32'd0);
    for (int c = 0; c < 20; c++) begin
      imem_ack = 1'($urandom);
      tick();
      check("halt:req_low", 32'(imem_req), 32'd0);
      check("halt:pc_frozen", 32'(pc), 32'd1);
    end
    imem_ack = 1'b0;
    check("halt:still_halted", 32'(halted), 32'd1);
`else
    hv = '{16'hF000, 8'h01, 1'b0, 1'b0, 0, 0, 8'h02};
    run_vec(hv, 11);
    check("nohalt:halted", 32'(halted), 32'd0);
    e = '{16'h0000, 8'h00};
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
